cla_pipe_adder: RTL and testbench

- Two-stage pipelined carry-lookahead adder/subtractor.
- It is the consumer of per-bit propagate/generate terms: the block forms p/g per bit, then produces group and block carries by lookahead.
- It sits between operand producers and the ALU result path.
- A valid/ready handshake on both sides allows back-to-back issue, one result per cycle.

---
 rtl/cla_pipe_adder.sv | 215 +++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 captures per-bit propagate/generate terms and the carry-in.
// Stage 2 forms group generate/propagate, resolves group carries with a
// second-level lookahead, resolves in-group carries, and registers the result.
// A valid/ready handshake on both sides sustains one result per cycle.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    // Carry-out of a GROUP-bit block when its carry-in is 0 (group generate).
    function automatic logic group_gen(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g);
        logic gg;
        logic t;
        gg = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            t = g[j];
            for (int m = j + 1; m < GROUP; m++) begin
                t = t & p[m];
            end
            gg = gg | t;
        end
        return gg;
    endfunction

    // Flattened lookahead carries inside one group from its carry-in.
    function automatic logic [GROUP:0] in_group_carries(input logic [GROUP-1:0] p,
                                                         input logic [GROUP-1:0] g,
                                                         input logic ci);
        logic [GROUP:0] c;
        logic           t;
        c    = {(GROUP+1){1'b0}};
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    t = t & p[m];
                end
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    // Flattened second-level lookahead across groups from the block carry-in.
    function automatic logic [NG:0] group_carries(input logic [NG-1:0] gg,
                                                  input logic [NG-1:0] gp,
                                                  input logic ci);
        logic [NG:0] c;
        logic        t;
        c    = {(NG+1){1'b0}};
        c[0] = ci;
        for (int i = 0; i < NG; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) begin
                t = t & gp[j];
            end
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = gg[j];
                for (int m = j + 1; m <= i; m++) begin
                    t = t & gp[m];
                end
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             c0_q, c0_d;

    // Output registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Combinational helpers
    logic             out_drain_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [NG-1:0]    gg_s;
    logic [NG-1:0]    gp_s;
    logic [NG:0]      gc_s;
    logic [WIDTH:0]   c_s;

    // Output register can take a new beat when empty or draining this cycle;
    // stage 1 may accept when empty or when it advances into the output.
    always_comb begin
        out_drain_s = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || out_drain_s;
    end

    // Stage 1 next state: p/g capture of (a, b or ~b) and the effective carry-in.
    always_comb begin
        b_eff_s    = sub ? ~b : b;
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        c0_d       = c0_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                p_d  = a ^ b_eff_s;
                g_d  = a & b_eff_s;
                c0_d = sub | cin;
            end else begin
                p_d  = p_q;
                g_d  = g_q;
                c0_d = c0_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 lookahead: group terms, group carries, then in-group carries.
    always_comb begin
        logic [GROUP:0] grp_c;
        gg_s  = {NG{1'b0}};
        gp_s  = {NG{1'b0}};
        c_s   = {(WIDTH+1){1'b0}};
        grp_c = {(GROUP+1){1'b0}};
        for (int k = 0; k < NG; k++) begin
            gg_s[k] = group_gen(p_q[k*GROUP +: GROUP], g_q[k*GROUP +: GROUP]);
            gp_s[k] = &p_q[k*GROUP +: GROUP];
        end
        gc_s = group_carries(gg_s, gp_s, c0_q);
        // Ascending order: each group's carry-out slot is then rewritten by
        // the next group's carry-in, which is the same value.
        for (int k = 0; k < NG; k++) begin
            grp_c = in_group_carries(p_q[k*GROUP +: GROUP], g_q[k*GROUP +: GROUP], gc_s[k]);
            c_s[k*GROUP +: GROUP+1] = grp_c;
        end
    end

    // Output next state: load on drain, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (out_drain_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = p_q ^ c_s[WIDTH-1:0];
                cout_d = gc_s[NG];
                ovf_d  = c_s[WIDTH-1] ^ c_s[WIDTH];
            end else begin
                sum_d  = sum_q;
                cout_d = cout_q;
                ovf_d  = ovf_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset discarding all in-flight beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            p_q         <= {WIDTH{1'b0}};
            g_q         <= {WIDTH{1'b0}};
            c0_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            g_q         <= g_d;
            c0_q        <= c0_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = out_valid_q;
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4).
module tb_cla_pipe_adder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks;
    int n_fail;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat with out_ready=1: accept edge, then result after the next edge.
    task automatic run_beat(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic sv, input logic cv, input logic [15:0] es,
                            input logic ec, input logic eo);
        a        = av;
        b        = bv;
        sub      = sv;
        cin      = cv;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        sub      = ~sv;
        cin      = ~cv;
        check({tag, "_early_valid"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        tick();
        check({tag, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        sub       = 1'b0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Input don't-cares while idle
        for (int i = 0; i < 4; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
            tick();
            check("idle_valid", out_valid, 1'b0);
        end

        // Arithmetic vectors
        run_beat("add",     16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);
        run_beat("carry1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_beat("carry2",  16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_beat("chain",   16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_beat("sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_beat("borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_beat("subovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_beat("cinonly", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);

        // Backpressure: four beats, out_ready low for the first four cycles
        out_ready = 1'b0;
        sub       = 1'b0;
        cin       = 1'b0;
        a         = 16'h0001;
        b         = 16'h0001;
        in_valid  = 1'b1;
        check("bp_rdy1", in_ready, 1'b1);
        tick();
        a = 16'h0002;
        b = 16'h0002;
        check("bp_rdy2", in_ready, 1'b1);
        tick();
        a = 16'h0003;
        b = 16'h0003;
        check("bp_full", in_ready, 1'b0);
        check("bp_v0", out_valid, 1'b1);
        check("bp_s0", sum, 16'h0002);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_full_hold", in_ready, 1'b0);
            check("bp_stall_valid", out_valid, 1'b1);
            check("bp_stall_sum", sum, 16'h0002);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", in_ready, 1'b1);
        tick();
        a = 16'h0004;
        b = 16'h0004;
        check("bp_r2_valid", out_valid, 1'b1);
        check("bp_r2_sum", sum, 16'h0004);
        tick();
        in_valid = 1'b0;
        check("bp_r3_valid", out_valid, 1'b1);
        check("bp_r3_sum", sum, 16'h0006);
        tick();
        check("bp_r4_valid", out_valid, 1'b1);
        check("bp_r4_sum", sum, 16'h0008);
        tick();
        check("bp_empty", out_valid, 1'b0);

        // Reset mid-flight
        out_ready = 1'b0;
        a         = 16'h0001;
        b         = 16'h0001;
        in_valid  = 1'b1;
        tick();
        a = 16'h0002;
        b = 16'h0002;
        tick();
        in_valid = 1'b0;
        check("mid_valid_pre", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_valid_async", out_valid, 1'b0);
        check("mid_sum_async", sum, 16'h0000);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_in_ready", in_ready, 1'b1);
        check("mid_no_replay", out_valid, 1'b0);
        out_ready = 1'b1;
        run_beat("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
